// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, optional FWFT read port,
// programmable almost-full/empty flags, sticky error flags and flush.
module sync_fifo_param #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_CNT_WIDTH  = $clog2(FIFO_DEPTH+1),
  parameter bit FWFT_MODE       = 1'b0,
  parameter int AF_THRESH       = FIFO_DEPTH-2,
  parameter int AE_THRESH       = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_clr,
  input  logic                       fifo_wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                       fifo_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                       fifo_rd_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_almost_full,
  output logic                       fifo_almost_empty,
  output logic [FIFO_CNT_WIDTH-1:0]  fifo_data_cnt,
  output logic                       fifo_overflow,
  output logic                       fifo_underflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH-1);
  localparam logic [FIFO_CNT_WIDTH-1:0] FULL_CNT = FIFO_CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [FIFO_CNT_WIDTH-1:0] AF_CNT = FIFO_CNT_WIDTH'(AF_THRESH);
  localparam logic [FIFO_CNT_WIDTH-1:0] AE_CNT = FIFO_CNT_WIDTH'(AE_THRESH);

  logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [FIFO_CNT_WIDTH-1:0]  r_cnt;
  logic                       r_ovf;
  logic                       r_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;

  assign w_full   = (r_cnt == FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_rd_acc = fifo_rd_en & ~w_empty;
  assign w_wr_acc = fifo_wr_en & (~w_full | w_rd_acc);
  assign w_wr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !fifo_clr) begin
      r_mem[r_wr_ptr] <= fifo_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (fifo_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_nxt;
      if (w_wr_acc && !w_rd_acc) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (fifo_wr_en && w_full && !w_rd_acc) r_ovf <= 1'b1;
      if (fifo_rd_en && w_empty) r_unf <= 1'b1;
    end
  end

  generate
    if (FWFT_MODE == 1'b0) begin : g_std
      logic [FIFO_DATA_WIDTH-1:0] r_rd_data;
      logic                       r_rd_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (fifo_clr) begin
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign fifo_rd_data  = r_rd_data;
      assign fifo_rd_valid = r_rd_valid;
    end else begin : g_fwft
      // Head word is presented combinationally; rd_en acts as the pop.
      assign fifo_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign fifo_rd_valid = ~w_empty;
    end
  endgenerate

  assign fifo_full         = w_full;
  assign fifo_empty        = w_empty;
  assign fifo_almost_full  = (r_cnt >= AF_CNT);
  assign fifo_almost_empty = (r_cnt <= AE_CNT);
  assign fifo_data_cnt     = r_cnt;
  assign fifo_overflow     = r_ovf;
  assign fifo_underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard and one FWFT instance of a
// depth-5 FIFO fed identical stimulus and checked against a queue model.
module tb_sync_fifo_param;

  localparam int D  = 5;
  localparam int DW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic clr, we, re;
  logic [DW-1:0] wd;

  logic [DW-1:0] s_data, f_data;
  logic s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] s_cnt, f_cnt;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .FIFO_DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT_MODE(1'b0),
    .AF_THRESH(3), .AE_THRESH(1)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .fifo_clr(clr),
    .fifo_wr_en(we), .fifo_wr_data(wd), .fifo_rd_en(re),
    .fifo_rd_data(s_data), .fifo_rd_valid(s_vld),
    .fifo_full(s_full), .fifo_empty(s_empty),
    .fifo_almost_full(s_af), .fifo_almost_empty(s_ae),
    .fifo_data_cnt(s_cnt),
    .fifo_overflow(s_ovf), .fifo_underflow(s_unf)
  );

  sync_fifo_param #(
    .FIFO_DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT_MODE(1'b1),
    .AF_THRESH(3), .AE_THRESH(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .fifo_clr(clr),
    .fifo_wr_en(we), .fifo_wr_data(wd), .fifo_rd_en(re),
    .fifo_rd_data(f_data), .fifo_rd_valid(f_vld),
    .fifo_full(f_full), .fifo_empty(f_empty),
    .fifo_almost_full(f_af), .fifo_almost_empty(f_ae),
    .fifo_data_cnt(f_cnt),
    .fifo_overflow(f_ovf), .fifo_underflow(f_unf)
  );

  // Reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_vld;
  logic          m_ovf, m_unf;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_cnt",   int'(s_cnt),   n);
    chk("s_empty", int'(s_empty), int'(n == 0));
    chk("s_full",  int'(s_full),  int'(n == D));
    chk("s_af",    int'(s_af),    int'(n >= 3));
    chk("s_ae",    int'(s_ae),    int'(n <= 1));
    chk("s_ovf",   int'(s_ovf),   int'(m_ovf));
    chk("s_unf",   int'(s_unf),   int'(m_unf));
    chk("s_vld",   int'(s_vld),   int'(m_vld));
    chk("s_data",  int'(s_data),  int'(m_data));
    chk("f_cnt",   int'(f_cnt),   n);
    chk("f_flags", int'({f_full, f_empty, f_af, f_ae, f_ovf, f_unf}),
        int'({n == D, n == 0, n >= 3, n <= 1, m_ovf, m_unf}));
    chk("f_vld",   int'(f_vld),   int'(n != 0));
    chk("f_data",  int'(f_data),  (n != 0) ? int'(q[0]) : 0);
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic cyc(input logic c, input logic w, input logic [DW-1:0] d,
                     input logic r);
    int  n;
    logic ra, wa;
    clr = c; we = w; wd = d; re = r;
    @(posedge clk);
    n  = q.size();
    ra = r && (n != 0);
    wa = w && ((n < D) || ra);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_vld = 1'b0;
    end else begin
      if (w && n == D && !ra) m_ovf = 1'b1;
      if (r && n == 0) m_unf = 1'b1;
      if (ra) begin
        m_data = q.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (wa) q.push_back(d);
    end
    #1;
    clr = 1'b0; we = 1'b0; re = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    int            cnt;
    logic          vld;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int vcnt;
    for (int i = 0; i < 5; i++) begin
      tbl[i].w = 1'b1; tbl[i].d = DW'(8'hA0 + i); tbl[i].r = 1'b0;
      tbl[i].cnt = i + 1; tbl[i].vld = 1'b0; tbl[i].dat = 8'h00;
    end
    for (int i = 0; i < 5; i++) begin
      tbl[5+i].w = 1'b0; tbl[5+i].d = 8'h00; tbl[5+i].r = 1'b1;
      tbl[5+i].cnt = 4 - i; tbl[5+i].vld = 1'b1;
      tbl[5+i].dat = DW'(8'hA0 + i);
    end
    tbl[10].w = 1'b0; tbl[10].d = 8'h00; tbl[10].r = 1'b0;
    tbl[10].cnt = 0; tbl[10].vld = 1'b0; tbl[10].dat = 8'hA4;

    rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed in-order transfer, standard read latency
    vcnt = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, tbl[i].w, tbl[i].d, tbl[i].r);
      chk("tbl_cnt", int'(s_cnt), tbl[i].cnt);
      chk("tbl_vld", int'(s_vld), int'(tbl[i].vld));
      chk("tbl_dat", int'(s_data), int'(tbl[i].dat));
      if (s_vld) vcnt++;
    end
    chk("vld_cycles", vcnt, 5);

    // Full boundary: simultaneous rd/wr, then dropped write
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, DW'(8'hB0 + i), 1'b0);
    chk("full_set", int'(s_full), 1);
    cyc(1'b0, 1'b1, 8'hC0, 1'b1);
    chk("full_rw_cnt", int'(s_cnt), 5);
    chk("full_rw_ovf", int'(s_ovf), 0);
    chk("full_rw_dat", int'(s_data), 8'hB0);
    cyc(1'b0, 1'b1, 8'hC1, 1'b0);
    chk("ovf_set", int'(s_ovf), 1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drop_last", int'(s_data), 8'hC0);

    // Empty boundary, then flush clears sticky flags
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("unf_set", int'(s_unf), 1);
    chk("unf_cnt", int'(s_cnt), 0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b1);
    chk("clr_cnt", int'(s_cnt), 0);
    chk("clr_ovf", int'(s_ovf), 0);
    chk("clr_unf", int'(s_unf), 0);

    // FWFT visibility one cycle after a write into empty
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    chk("fwft_vld", int'(f_vld), 1);
    chk("fwft_dat", int'(f_data), 8'h55);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft_pop", int'(f_vld), 0);

    // Threshold stepping 0->4->0
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, DW'(i), 1'b0);
    chk("af_at4", int'(s_af), 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ae_at0", int'(s_ae), 1);

    // Reset asserted mid-fill
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DW'(8'hE0 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic across pointer wrap, with rare flushes
    for (int i = 0; i < 400; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 99) < ((i < 200) ? 65 : 40));
      r = ($urandom_range(0, 99) < ((i < 200) ? 40 : 65));
      c = ($urandom_range(0, 63) == 0);
      cyc(c, w, DW'($urandom), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
